// File: rtl/fp_align_if.sv
// fp_align_if: operand/result handshake bundle for fp_align_unit.
//   Operand side : in_valid, in_ready, op_a[31:0], op_b[31:0], sub
//   Result side  : out_valid, out_ready, exp_big[7:0], mant_big[26:0],
//                  mant_sml[26:0], sign_big, eff_sub, swapped, out_special
//   master = upstream/downstream environment, slave = alignment unit.
interface fp_align_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_big;
    logic [26:0] mant_big;
    logic [26:0] mant_sml;
    logic        sign_big;
    logic        eff_sub;
    logic        swapped;
    logic        out_special;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, exp_big, mant_big, mant_sml,
               sign_big, eff_sub, swapped, out_special
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, exp_big, mant_big, mant_sml,
               sign_big, eff_sub, swapped, out_special
    );
endinterface

// File: rtl/fp_align_unit.sv
// fp_align_unit: multi-cycle FP32 add/sub alignment (exponent compare, swap,
// bounded per-cycle right shift of the smaller mantissa with G/R/S tracking).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fp_align_if.slave (operand in handshake, aligned result out handshake)
//   SHIFT_STEP : max right-shift bits per SHIFT cycle (1..8)
module fp_align_unit #(
    parameter int SHIFT_STEP = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    fp_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t      state_q;
    logic [31:0] a_q, b_q;
    logic        sub_q;
    logic [4:0]  rem_q;
    logic [7:0]  exp_big_q;
    logic [26:0] mant_big_q, mant_sml_q;
    logic        sign_big_q, eff_sub_q, swapped_q, special_q, out_valid_q;

    logic        ha, hb, swap, special, sign_b_eff, lost;
    logic [7:0]  ea, eb, abs_d;
    logic [8:0]  d;
    logic [26:0] ma, mb, m_sml, shifted_d;
    logic [4:0]  k;

    // Denormals (exponent field 0) have no hidden bit and act as exponent 1.
    assign ha         = |a_q[30:23];
    assign hb         = |b_q[30:23];
    assign ea         = ha ? a_q[30:23] : 8'd1;
    assign eb         = hb ? b_q[30:23] : 8'd1;
    assign ma         = {ha, a_q[22:0], 3'b000};
    assign mb         = {hb, b_q[22:0], 3'b000};
    assign d          = {1'b0, ea} - {1'b0, eb};
    assign abs_d      = d[8] ? (eb - ea) : (ea - eb);
    assign swap       = d[8] | ((d == 9'd0) & (mb > ma));
    assign m_sml      = swap ? ma : mb;
    assign special    = (&a_q[30:23]) | (&b_q[30:23]);
    assign sign_b_eff = b_q[31] ^ sub_q;

    // Old S sits at bit 0, so it is always among the shifted-out bits and
    // folds into the new sticky without a separate term.
    assign k          = (rem_q < STEP) ? rem_q : STEP;
    assign lost       = |(mant_sml_q & ~({27{1'b1}} << k));
    assign shifted_d  = (mant_sml_q >> k) | {26'd0, lost};

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.exp_big     = exp_big_q;
    assign bus.mant_big    = mant_big_q;
    assign bus.mant_sml    = mant_sml_q;
    assign bus.sign_big    = sign_big_q;
    assign bus.eff_sub     = eff_sub_q;
    assign bus.swapped     = swapped_q;
    assign bus.out_special = special_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            rem_q       <= '0;
            exp_big_q   <= '0;
            mant_big_q  <= '0;
            mant_sml_q  <= '0;
            sign_big_q  <= 1'b0;
            eff_sub_q   <= 1'b0;
            swapped_q   <= 1'b0;
            special_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.op_a;
                    b_q     <= bus.op_b;
                    sub_q   <= bus.sub;
                    state_q <= CMP;
                end
                CMP: begin
                    exp_big_q  <= swap ? eb : ea;
                    mant_big_q <= swap ? mb : ma;
                    sign_big_q <= swap ? sign_b_eff : a_q[31];
                    eff_sub_q  <= a_q[31] ^ sign_b_eff;
                    swapped_q  <= swap;
                    special_q  <= special;
                    rem_q      <= abs_d[4:0];
                    if (special || abs_d == 8'd0) begin
                        mant_sml_q  <= m_sml;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (abs_d >= 8'd27) begin
                        // Everything falls below bit 0: only sticky survives.
                        mant_sml_q  <= {26'd0, |m_sml};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        mant_sml_q <= m_sml;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    mant_sml_q <= shifted_d;
                    rem_q      <= rem_q - k;
                    if (rem_q == k) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_unit.sv
// tb_fp_align_unit: directed-vector self-checking bench for fp_align_unit
// (SHIFT_STEP = 4): result fields, latency, backpressure and mid-op reset.
module tb_fp_align_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_align_if bus ();
    fp_align_unit #(.SHIFT_STEP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [7:0]  e;
        logic [26:0] mb;
        logic [26:0] ms;
        logic        sb;
        logic        es;
        logic        sw;
        logic        sp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input vec_t v, input string tag);
        chk({tag, "_exp_big"},  32'(bus.exp_big),     32'(v.e));
        chk({tag, "_mant_big"}, 32'(bus.mant_big),    32'(v.mb));
        chk({tag, "_mant_sml"}, 32'(bus.mant_sml),    32'(v.ms));
        chk({tag, "_sign_big"}, 32'(bus.sign_big),    32'(v.sb));
        chk({tag, "_eff_sub"},  32'(bus.eff_sub),     32'(v.es));
        chk({tag, "_swapped"},  32'(bus.swapped),     32'(v.sw));
        chk({tag, "_special"},  32'(bus.out_special), 32'(v.sp));
    endtask

    task automatic start(input vec_t v, input string tag);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op_a = v.a;
        bus.op_b = v.b;
        bus.sub = v.sub;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input vec_t v, input string tag);
        int lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check_outs(v, tag);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ov_clear"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle"},     32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        //         op_a          op_b          sub   exp    mant_big      mant_sml      sb    es    sw    sp   lat
        vecs[0]  = '{32'h40400000, 32'h3F800000, 1'b0, 8'h80, 27'h6000000, 27'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b0, 8'h80, 27'h6000000, 27'h2000000, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[2]  = '{32'h3F800000, 32'hBFC00000, 1'b0, 8'h7F, 27'h6000000, 27'h4000000, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        vecs[3]  = '{32'h4B000000, 32'h3F800001, 1'b0, 8'h96, 27'h4000000, 27'h0000009, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        vecs[4]  = '{32'h64000000, 32'h3F800000, 1'b0, 8'hC8, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vecs[6]  = '{32'h00000001, 32'h00800000, 1'b0, 8'h01, 27'h4000000, 27'h0000008, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[7]  = '{32'h40000000, 32'h40000000, 1'b1, 8'h80, 27'h4000000, 27'h4000000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[8]  = '{32'h42000000, 32'h3F900000, 1'b0, 8'h84, 27'h4000000, 27'h0240000, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[9]  = '{32'h64000000, 32'h00000000, 1'b0, 8'hC8, 27'h4000000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{32'h4D000000, 32'h3F800000, 1'b0, 8'h9A, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[11] = '{32'h4C800000, 32'h3F800000, 1'b0, 8'h99, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[12] = '{32'h3F800000, 32'h40400000, 1'b1, 8'h80, 27'h6000000, 27'h2000000, 1'b1, 1'b1, 1'b1, 1'b0, 3};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.sub = 1'b0;

        #12;
        chk("rst_in_ready",  32'(bus.in_ready),    32'd1);
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_exp_big",   32'(bus.exp_big),     32'd0);
        chk("rst_mant_big",  32'(bus.mant_big),    32'd0);
        chk("rst_mant_sml",  32'(bus.mant_sml),    32'd0);
        chk("rst_special",   32'(bus.out_special), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start(vecs[i], $sformatf("v%0d", i));
            wait_done(vecs[i], $sformatf("v%0d", i));
            handshake($sformatf("v%0d", i));
        end

        // Backpressure: result must stay valid and bit-stable while out_ready is low.
        start(vecs[3], "bp");
        wait_done(vecs[3], "bp");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_ready", c), 32'(bus.in_ready),  32'd0);
            check_outs(vecs[3], $sformatf("bp%0d", c));
        end
        handshake("bp");

        // Reset during SHIFT aborts the operation with no partial output.
        start(vecs[11], "rs");
        repeat (3) @(posedge clk);
        #1;
        chk("rs_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rs_mant_sml",  32'(bus.mant_sml),  32'd0);
        chk("rs_exp_big",   32'(bus.exp_big),   32'd0);
        @(posedge clk); #1;
        chk("rs_held_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        start(vecs[0], "post_rs");
        wait_done(vecs[0], "post_rs");
        handshake("post_rs");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
